// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_ctrl
//  Description : Converts three signed operands (A, B, result D) to decimal
//                with a shared one-bit-per-cycle double-dabble engine and
//                drives two active-low 7-segment display halves. The top digit
//                of each half carries the sign. Overflow mode shows a
//                blinking "Erro" on the lower half.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                a_val, b_val, d_val - signed operands / result (WIDTH bits)
//                overflow, key       - display mode selectors (captured)
//                update              - single-cycle convert/refresh request
//                busy                - conversion in progress
//                ready               - one-cycle pulse on display refresh
//                hex_hi, hex_lo      - segments {g..a} per digit, MS digit in
//                                      MS bits
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
   parameter int WIDTH       = 10,
   parameter int DIGITS      = 4,
   parameter int BLINK_BITS  = 24,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      a_val,
   input  logic [WIDTH-1:0]      b_val,
   input  logic [WIDTH-1:0]      d_val,
   input  logic                  overflow,
   input  logic                  key,
   input  logic                  update,
   output logic                  busy,
   output logic                  ready,
   output logic [7*DIGITS-1:0]   hex_hi,
   output logic [7*DIGITS-1:0]   hex_lo
);

   localparam int ND    = DIGITS - 1;       // numeric digits per half
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_O     = 7'b0100011;

   function automatic logic [63:0] pow10_minus1(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   // Largest magnitude that fits in the numeric digits of one half
   localparam logic [63:0] LIMIT = pow10_minus1(ND);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      CONV_A  = 3'd2,
      CONV_B  = 3'd3,
      CONV_D  = 3'd4,
      COMMIT  = 3'd5
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0]      cap_a, cap_b, cap_d;
   logic                  cap_ovf, cap_key;
   logic [WIDTH-1:0]      mag_a, mag_b, mag_d;
   logic                  neg_a, neg_b, neg_d;
   logic [WIDTH-1:0]      shreg;
   logic [4*ND-1:0]       bcd, bcd_adj, bcd_shift;
   logic [4*ND-1:0]       bcd_a, bcd_b, bcd_d;
   logic [CNT_W-1:0]      cnt;
   logic                  cnt_last;
   logic [BLINK_BITS-1:0] blink;
   logic                  ovf_mode;
   logic [7*DIGITS-1:0]   hex_hi_r, hex_lo_r;
   logic [7*DIGITS-1:0]   disp_hi, disp_lo;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      // -2^(WIDTH-1) wraps onto itself, which is the correct unsigned magnitude
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0011000;
         default: return SEG_BLANK;
      endcase
   endfunction

   function automatic logic [7*DIGITS-1:0] fmt_num(input logic [4*ND-1:0] b,
                                                   input logic neg,
                                                   input logic [WIDTH-1:0] mag);
      logic [7*DIGITS-1:0] r;
      logic                seen;
      logic                over;
      r    = '1;
      seen = 1'b0;
      over = (64'(mag) > LIMIT);
      r[7*(DIGITS-1) +: 7] = neg ? SEG_DASH : SEG_BLANK;
      // Walk from the top digit so "seen" marks the first nonzero digit
      for (int i = ND - 1; i >= 0; i--) begin
         if (b[4*i +: 4] != 4'd0) seen = 1'b1;
         if (over)
            r[7*i +: 7] = SEG_DASH;
         else if ((LZ_SUPPRESS != 0) && !seen && (i != 0))
            r[7*i +: 7] = SEG_BLANK;
         else
            r[7*i +: 7] = seg7(b[4*i +: 4]);
      end
      return r;
   endfunction

   function automatic logic [7*DIGITS-1:0] fmt_err();
      logic [7*DIGITS-1:0] r;
      r = '1;
      r[7*(DIGITS-1) +: 7] = SEG_E;
      r[7*(DIGITS-2) +: 7] = SEG_R;
      r[7*(DIGITS-3) +: 7] = SEG_R;
      r[7*(DIGITS-4) +: 7] = SEG_O;
      return r;
   endfunction

   // Shift-add-3: bump every BCD digit >= 5 before shifting in the next bit
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < ND; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign bcd_shift = {bcd_adj[4*ND-2:0], shreg[WIDTH-1]};
   assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      disp_hi = cap_key ? '1 : fmt_num(bcd_a, neg_a, mag_a);
      if (!cap_key)
         disp_lo = fmt_num(bcd_b, neg_b, mag_b);
      else if (cap_ovf)
         disp_lo = fmt_err();
      else
         disp_lo = fmt_num(bcd_d, neg_d, mag_d);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      case (state)
         IDLE:    if (update) state_next = CAPTURE;
         CAPTURE: state_next = CONV_A;
         CONV_A:  if (cnt_last) state_next = CONV_B;
         CONV_B:  if (cnt_last) state_next = CONV_D;
         CONV_D:  if (cnt_last) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_a    <= '0;
         cap_b    <= '0;
         cap_d    <= '0;
         cap_ovf  <= 1'b0;
         cap_key  <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         mag_d    <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         neg_d    <= 1'b0;
         shreg    <= '0;
         bcd      <= '0;
         bcd_a    <= '0;
         bcd_b    <= '0;
         bcd_d    <= '0;
         cnt      <= '0;
         blink    <= '0;
         ready    <= 1'b0;
         ovf_mode <= 1'b0;
         hex_hi_r <= '1;
         hex_lo_r <= '1;
      end else begin
         blink <= blink + 1'b1;
         // Registered so the pulse coincides with the refreshed outputs
         ready <= (state == COMMIT);
         case (state)
            IDLE: begin
               if (update) begin
                  cap_a   <= a_val;
                  cap_b   <= b_val;
                  cap_d   <= d_val;
                  cap_ovf <= overflow;
                  cap_key <= key;
               end
            end
            CAPTURE: begin
               mag_a <= abs_val(cap_a);
               mag_b <= abs_val(cap_b);
               mag_d <= abs_val(cap_d);
               neg_a <= cap_a[WIDTH-1];
               neg_b <= cap_b[WIDTH-1];
               neg_d <= cap_d[WIDTH-1];
               shreg <= abs_val(cap_a);
               bcd   <= '0;
               cnt   <= '0;
            end
            CONV_A, CONV_B, CONV_D: begin
               shreg <= shreg << 1;
               bcd   <= bcd_shift;
               cnt   <= cnt + 1'b1;
               if (cnt_last) begin
                  bcd <= '0;
                  cnt <= '0;
                  if (state == CONV_A) begin
                     bcd_a <= bcd_shift;
                     shreg <= mag_b;
                  end else if (state == CONV_B) begin
                     bcd_b <= bcd_shift;
                     shreg <= mag_d;
                  end else begin
                     bcd_d <= bcd_shift;
                  end
               end
            end
            COMMIT: begin
               hex_hi_r <= disp_hi;
               hex_lo_r <= disp_lo;
               ovf_mode <= cap_key & cap_ovf;
            end
            default: ;
         endcase
      end
   end

   assign hex_hi = hex_hi_r;
   assign hex_lo = (ovf_mode && blink[BLINK_BITS-1]) ? '1 : hex_lo_r;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_ctrl
//  Description : Directed self-checking bench for seg_display_ctrl. Three
//                instances: WIDTH=10/BLINK_BITS=4 (main), WIDTH=10 with
//                leading zeros shown, and WIDTH=12.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DA = 7'b0111111;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] SR = 7'b0101111;
   localparam logic [6:0] SO = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  a_val = '0, b_val = '0, d_val = '0;
   logic [11:0] d12 = '0;
   logic        overflow = 1'b0, key = 1'b0, update = 1'b0;

   logic        busy, ready, busy1, ready1, busy2, ready2;
   logic [27:0] hex_hi, hex_lo, hex_hi1, hex_lo1, hex_hi2, hex_lo2;

   logic [3:0]  blink_ref = '0;
   int          n_pass = 0;
   int          n_checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) blink_ref <= '0;
      else     blink_ref <= blink_ref + 4'd1;
   end

   seg_display_ctrl #(.WIDTH(10), .DIGITS(4), .BLINK_BITS(4), .LZ_SUPPRESS(1)) dut (
      .clk(clk), .rst(rst), .a_val(a_val), .b_val(b_val), .d_val(d_val),
      .overflow(overflow), .key(key), .update(update),
      .busy(busy), .ready(ready), .hex_hi(hex_hi), .hex_lo(hex_lo));

   seg_display_ctrl #(.WIDTH(10), .DIGITS(4), .LZ_SUPPRESS(0)) dut_lz0 (
      .clk(clk), .rst(rst), .a_val(a_val), .b_val(b_val), .d_val(d_val),
      .overflow(overflow), .key(key), .update(update),
      .busy(busy1), .ready(ready1), .hex_hi(hex_hi1), .hex_lo(hex_lo1));

   seg_display_ctrl #(.WIDTH(12), .DIGITS(4)) dut_w12 (
      .clk(clk), .rst(rst), .a_val(12'd0), .b_val(12'd0), .d_val(d12),
      .overflow(overflow), .key(key), .update(update),
      .busy(busy2), .ready(ready2), .hex_hi(hex_hi2), .hex_lo(hex_lo2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called at a negedge; update is sampled at the following posedge, and the
   // task returns at the negedge after that edge (cycle 0).
   task automatic go(input logic [9:0] a, input logic [9:0] b, input logic [9:0] d,
                     input logic [11:0] dw, input logic ovf, input logic k);
      a_val = a; b_val = b; d_val = d; d12 = dw; overflow = ovf; key = k;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   task automatic wait_ready(inout int k);
      while (!ready && k < 100) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int k;
      int pulses;
      logic [27:0] held;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      check("rst_hex_hi", hex_hi, {4{BL}});
      check("rst_hex_lo", hex_lo, {4{BL}});
      rst = 1'b0;
      @(negedge clk);

      // A=123, B=-45, key=0, with a second update while busy that must be ignored
      go(10'd123, 10'(-45), 10'd0, 12'd0, 1'b0, 1'b0);
      check("busy_after_update", busy, 1);
      repeat (5) @(negedge clk);
      a_val = 10'd1; b_val = 10'd2; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      k = 6;
      wait_ready(k);
      check("latency_ab", k, 32);
      check("hex_hi_123", hex_hi, {BL, S1, S2, S3});
      check("hex_lo_m45", hex_lo, {DA, BL, S4, S5});
      @(negedge clk);
      check("ready_one_cycle", ready, 0);
      check("busy_idle", busy, 0);
      held = hex_lo;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      check("ignored_update_no_ready", pulses, 0);
      check("no_blink_key0", hex_lo, held);
      check("hold_hex_hi", hex_hi, {BL, S1, S2, S3});

      // D=-512 key=1; WIDTH=12 instance gets D=2047 (exceeds three digits)
      go(10'd0, 10'd0, 10'h200, 12'd2047, 1'b0, 1'b1);
      k = 0;
      wait_ready(k);
      check("latency_d", k, 32);
      check("ready_lz0", ready1, 1);
      check("hex_hi_key1", hex_hi, {4{BL}});
      check("hex_lo_m512", hex_lo, {DA, S5, S1, S2});
      check("hex_lo_m512_lz0", hex_lo1, {DA, S5, S1, S2});
      while (!ready2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("latency_w12", k, 38);
      check("hex_lo_w12_2047", hex_lo2, {BL, DA, DA, DA});
      check("hex_hi_w12", hex_hi2, {4{BL}});
      repeat (3) @(negedge clk);

      // D=0 with and without leading-zero blanking
      go(10'd0, 10'd0, 10'd0, 12'd0, 1'b0, 1'b1);
      k = 0;
      wait_ready(k);
      check("latency_zero", k, 32);
      check("hex_lo_zero_lz1", hex_lo, {BL, BL, BL, S0});
      check("hex_lo_zero_lz0", hex_lo1, {BL, S0, S0, S0});

      // Back-to-back: issue overflow-mode update in the ready (IDLE) cycle
      go(10'd5, 10'd5, 10'd5, 12'd0, 1'b1, 1'b1);
      k = 0;
      wait_ready(k);
      check("latency_b2b", k, 32);
      check("hex_hi_ovf", hex_hi, {4{BL}});
      for (int i = 0; i < 32; i++) begin
         check($sformatf("blink_%0d", i), hex_lo,
               blink_ref[3] ? {4{BL}} : {SE, SR, SR, SO});
         @(negedge clk);
      end

      // Reset mid-conversion with update held high on the reset edge
      go(10'd7, 10'd8, 10'd9, 12'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1; update = 1'b1;
      @(negedge clk);
      rst = 1'b0; update = 1'b0;
      check("abort_busy", busy, 0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      check("abort_no_ready", pulses, 0);
      check("abort_hex_hi", hex_hi, {4{BL}});
      check("abort_hex_lo", hex_lo, {4{BL}});
      check("abort_busy_after", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
